// File: rtl/afe_pix_capture_if.sv
// Pixel output stream: {sof, eol, 16-bit word} with valid/ready handshake.
// The master holds data/sof/eol stable while valid is high and ready is low.
interface afe_pix_capture_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;

  modport master (
    output out_data,
    output out_valid,
    output out_sof,
    output out_eol,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sof,
    input  out_eol,
    output out_ready
  );
endinterface

// File: rtl/afe_pix_capture.sv
// AFE pixel capture: aligns AFE words to delayed TG syncs, crops a window, queues {sof,eol,pixel}.
// Latency 2 cycles from delayed hsync to out_valid; output held while stalled, pixels dropped when full.
module afe_pix_capture #(
  parameter int DW      = 14,
  parameter int AFE_LAT = 16,
  parameter int FIFO_AW = 9,
  parameter int CW      = 12
) (
  input  logic                 clk_pix,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 tg_vsync,
  input  logic                 tg_hsync,
  input  logic [DW-1:0]        afe_data,
  input  logic [CW-1:0]        cfg_x0,
  input  logic [CW-1:0]        cfg_xlen,
  input  logic [CW-1:0]        cfg_y0,
  input  logic [CW-1:0]        cfg_ylen,
  afe_pix_capture_if.master    out_if,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 err_short
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int WW    = DW + 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic hs_dly;
  logic vs_dly;

  generate
    if (AFE_LAT == 0) begin : g_nodly
      assign hs_dly = tg_hsync;
      assign vs_dly = tg_vsync;
    end else begin : g_dly
      logic [AFE_LAT-1:0] hs_sr_q, hs_sr_d;
      logic [AFE_LAT-1:0] vs_sr_q, vs_sr_d;

      always_comb begin
        hs_sr_d    = hs_sr_q << 1;
        hs_sr_d[0] = tg_hsync;
        vs_sr_d    = vs_sr_q << 1;
        vs_sr_d[0] = tg_vsync;
      end

      always_ff @(posedge clk_pix) begin
        if (rst) begin
          hs_sr_q <= '0;
          vs_sr_q <= '0;
        end else begin
          hs_sr_q <= hs_sr_d;
          vs_sr_q <= vs_sr_d;
        end
      end

      assign hs_dly = hs_sr_q[AFE_LAT-1];
      assign vs_dly = vs_sr_q[AFE_LAT-1];
    end
  endgenerate

  logic              hs_prev_q, hs_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     x_q, x_d;
  logic [CW-1:0]     y_q, y_d;
  logic              sof_pend_q, sof_pend_d;
  logic [CW-1:0]     x0_q, x0_d, xlen_q, xlen_d;
  logic [CW-1:0]     y0_q, y0_d, ylen_q, ylen_d;
  logic              overflow_q, overflow_d;
  logic              err_short_q, err_short_d;
  logic              frame_done_q, frame_done_d;

  logic [WW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ov_q, ov_d;
  logic [WW-1:0]      ow_q, ow_d;

  logic               hs_fall;
  logic               vs_rise;
  logic [CW:0]        x_ext, y_ext, x_end, y_end;
  logic               in_win;
  logic               is_eol;
  logic               last_line;
  logic [FIFO_AW+1:0] occ;
  logic               full;
  logic               push;
  logic               pop;
  logic [WW-1:0]      push_word;

  assign hs_fall = hs_prev_q & ~hs_dly;
  assign vs_rise = vs_dly & ~vs_prev_q;

  // Window bounds carry one extra bit so x0+xlen never wraps into the window.
  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};
  assign x_end = {1'b0, x0_q} + {1'b0, xlen_q};
  assign y_end = {1'b0, y0_q} + {1'b0, ylen_q};

  assign in_win = (state_q == ST_ACTIVE) && !vs_rise && hs_dly &&
                  (y_ext >= {1'b0, y0_q}) && (y_ext < y_end) &&
                  (x_ext >= {1'b0, x0_q}) && (x_ext < x_end);
  assign is_eol    = (x_ext == x_end - (CW+1)'(1));
  assign last_line = (ylen_q == '0) || (y_ext == y_end - (CW+1)'(1));

  // Capacity counts the output register too, so DEPTH words are held in total.
  assign occ       = {1'b0, cnt_q} + (FIFO_AW+2)'(ov_q);
  assign full      = (occ >= (FIFO_AW+2)'(DEPTH));
  assign push      = in_win && !full;
  assign pop       = (cnt_q != '0) && (!ov_q || out_if.out_ready);
  assign push_word = {sof_pend_q, is_eol, afe_data};

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sof_pend_d   = sof_pend_q;
    x0_d         = x0_q;
    xlen_d       = xlen_q;
    y0_d         = y0_q;
    ylen_d       = ylen_q;
    overflow_d   = overflow_q;
    err_short_d  = err_short_q;
    frame_done_d = 1'b0;
    hs_prev_d    = hs_dly;
    vs_prev_d    = vs_dly;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d     = ST_WAIT_VS;
          x0_d        = cfg_x0;
          xlen_d      = cfg_xlen;
          y0_d        = cfg_y0;
          ylen_d      = cfg_ylen;
          overflow_d  = 1'b0;
          err_short_d = 1'b0;
        end
      end
      ST_WAIT_VS: begin
        if (vs_rise) begin
          state_d    = ST_ACTIVE;
          x_d        = '0;
          y_d        = '0;
          sof_pend_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          err_short_d = 1'b1;
          x_d         = '0;
          y_d         = '0;
          sof_pend_d  = 1'b1;
        end else if (hs_dly) begin
          if (x_q != '1) x_d = x_q + CW'(1);
        end else if (hs_fall) begin
          if (last_line) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else begin
            x_d = '0;
            if (y_q != '1) y_d = y_q + CW'(1);
          end
        end
        if (in_win) begin
          sof_pend_d = 1'b0;
          if (full) overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    ow_d     = ow_q;

    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    if (push && !pop)      cnt_d = cnt_q + (FIFO_AW+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (FIFO_AW+1)'(1);

    if (ov_q && out_if.out_ready) ov_d = 1'b0;
    if (pop) begin
      ov_d = 1'b1;
      ow_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_pix) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      sof_pend_q   <= 1'b0;
      x0_q         <= '0;
      xlen_q       <= '0;
      y0_q         <= '0;
      ylen_q       <= '0;
      overflow_q   <= 1'b0;
      err_short_q  <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ov_q         <= 1'b0;
      ow_q         <= '0;
    end else begin
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sof_pend_q   <= sof_pend_d;
      x0_q         <= x0_d;
      xlen_q       <= xlen_d;
      y0_q         <= y0_d;
      ylen_q       <= ylen_d;
      overflow_q   <= overflow_d;
      err_short_q  <= err_short_d;
      frame_done_q <= frame_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ov_q         <= ov_d;
      ow_q         <= ow_d;
    end
  end

  assign out_if.out_data  = {{(16-DW){1'b0}}, ow_q[DW-1:0]};
  assign out_if.out_eol   = ow_q[DW];
  assign out_if.out_sof   = ow_q[DW+1];
  assign out_if.out_valid = ov_q;

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign err_short  = err_short_q;

endmodule
